// File: rtl/cpu_tick_pkg.sv
// rtl/cpu_tick_pkg.sv - mode encodings and FSM state type for the CPU tick generator
package cpu_tick_pkg;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT,
        ST_RUN,
        ST_STEP,
        ST_BURST
    } state_t;

    function automatic state_t mode_to_state(input logic [1:0] m);
        state_t s;
        case (m)
            MODE_RUN:   s = ST_RUN;
            MODE_STEP:  s = ST_STEP;
            MODE_BURST: s = ST_BURST;
            default:    s = ST_HALT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cpu_tick_if.sv
// rtl/cpu_tick_if.sv - control inputs and strobe outputs of the CPU tick generator
interface cpu_tick_if #(
    parameter int CNT_W   = 20,
    parameter int BURST_W = 8,
    parameter int TICK_W  = 16
);
    logic [1:0]         mode;
    logic [CNT_W-1:0]   div_val;
    logic               step_btn;
    logic [BURST_W-1:0] burst_len;
    logic               cpu_en;
    logic               busy;
    logic [TICK_W-1:0]  tick_count;

    modport master (
        output mode, div_val, step_btn, burst_len,
        input  cpu_en, busy, tick_count
    );

    modport slave (
        input  mode, div_val, step_btn, burst_len,
        output cpu_en, busy, tick_count
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, debounce counter and press pulse
module btn_debounce #(
    parameter int DB_W = 16
) (
    input  logic clk,
    input  logic master_reset,
    input  logic btn_i,
    output logic step_evt_o
);
    logic            sync0_q, sync1_q;
    logic            level_q, level_d;
    logic            evt_q, evt_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Level flips only after the synced input has disagreed for a full counter span.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        evt_d   = 1'b0;
        if (sync1_q != level_q) begin
            if (cnt_q == {DB_W{1'b1}}) begin
                level_d = sync1_q;
                evt_d   = sync1_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (master_reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            level_q <= 1'b0;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= btn_i;
            sync1_q <= sync0_q;
            level_q <= level_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign step_evt_o = evt_q;

endmodule

// File: rtl/cpu_tick_gen.sv
// rtl/cpu_tick_gen.sv - CPU clock-enable generator: prescaler, mode FSM, burst and tick counters
module cpu_tick_gen
    import cpu_tick_pkg::*;
#(
    parameter int CNT_W   = 20,
    parameter int DB_W    = 16,
    parameter int BURST_W = 8,
    parameter int TICK_W  = 16
) (
    input  logic      clk,
    input  logic      master_reset,
    cpu_tick_if.slave bus
);
    logic [1:0]         mode_q;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_eff;
    logic [BURST_W-1:0] rem_q, rem_d, rem_eff;
    logic               busy_q, busy_d;
    logic               cpu_en_q, cpu_en_d;
    logic [TICK_W-1:0]  tick_q;
    logic               step_evt;

    btn_debounce #(.DB_W(DB_W)) u_debounce (
        .clk          (clk),
        .master_reset (master_reset),
        .btn_i        (bus.step_btn),
        .step_evt_o   (step_evt)
    );

    // An idle burst treats the trigger cycle as prescaler count 0, so the first
    // strobe lands div_val+1 cycles after the trigger.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        cpu_en_d = 1'b0;
        cnt_eff  = busy_q ? cnt_q : '0;
        rem_eff  = busy_q ? rem_q : bus.burst_len;
        if (bus.mode != mode_q) begin
            state_d = mode_to_state(bus.mode);
            cnt_d   = '0;
            rem_d   = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cnt_q >= bus.div_val) begin
                        cpu_en_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STEP: cpu_en_d = step_evt;
                ST_BURST: begin
                    if (busy_q || (step_evt && bus.burst_len != '0)) begin
                        if (cnt_eff >= bus.div_val) begin
                            cpu_en_d = 1'b1;
                            cnt_d    = '0;
                            rem_d    = rem_eff - BURST_W'(1);
                            busy_d   = (rem_eff != BURST_W'(1));
                        end else begin
                            cnt_d  = cnt_eff + CNT_W'(1);
                            rem_d  = rem_eff;
                            busy_d = 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (master_reset) begin
            mode_q   <= MODE_HALT;
            state_q  <= ST_HALT;
            cnt_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            cpu_en_q <= 1'b0;
            tick_q   <= '0;
        end else begin
            mode_q   <= bus.mode;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            cpu_en_q <= cpu_en_d;
            tick_q   <= tick_q + TICK_W'(cpu_en_q);
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.busy       = busy_q;
    assign bus.tick_count = tick_q;

endmodule

// File: doc/cpu_tick_gen.md
# cpu_tick_gen

Parametrised CPU clock-enable generator that replaces the fixed 20-bit ripple divider in front of the 8-bit CPU core. Instead of producing a derived clock, it emits a single-cycle `cpu_en` strobe in the system clock domain. It supports halt, free-run at a programmable rate, single-step from a debounced push-button, and N-cycle burst modes. It sits at the top level between `clk`/`master_reset` and the CPU block, and the CPU qualifies every register update with `cpu_en`.

## Interface
- `CNT_W`, 20, prescaler width; free-run period is `div_val+1` cycles, maximum 2^CNT_W.
- `DB_W`, 16, debounce counter width; button must be stable for 2^DB_W cycles.
- `BURST_W`, 8, width of `burst_len`.
- `TICK_W`, 16, width of `tick_count`.
- `clk`  in  1  system clock; the only clock.
- `master_reset`  in  1  synchronous, active-high reset.
- `mode`  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST; quasi-static.
- `div_val`  in  CNT_W  RUN/BURST terminal count.
- `step_btn`  in  1  raw asynchronous push-button, active-high.
- `burst_len`  in  BURST_W  number of strobes per burst; sampled on the trigger.
- `cpu_en`  out  1  registered one-cycle CPU enable strobe.
- `busy`  out  1  high while a burst is in progress.
- `tick_count`  out  TICK_W  total strobes issued; wraps modulo 2^TICK_W.

## Operation
- Reset: all outputs 0; FSM in HALT; prescaler, debounce counter and synchroniser flops 0; debounced level 0.
- `mode` is registered (`mode_q`).
  - When `mode != mode_q`, the prescaler clears, any burst aborts (`busy` goes 0) and `cpu_en` is 0 that cycle.
  - The FSM then enters the state matching the new mode.
- Button path:
  - 2-flop synchroniser.
  - Debounce counter increments each cycle the synced level differs from the debounced level, and clears when they match.
  - When the counter equals 2^DB_W−1 and the levels still differ, the debounced level flips and the counter clears.
  - `step_evt` is the rising edge of the debounced level. Releases produce no event.
- FSM states HALT, RUN, STEP, BURST:
  - HALT: `cpu_en` held 0; `step_evt` ignored.
  - RUN: prescaler counts from 0. When `cnt >= div_val`, `cpu_en` <= 1 and `cnt` <= 0; otherwise `cnt` increments. `>=` means lowering `div_val` below the current count wraps on the next cycle. `div_val=0` gives `cpu_en` every cycle.
  - STEP: each `step_evt` produces exactly one `cpu_en` strobe, on the following cycle.
  - BURST:
    - Idle: `step_evt` loads `remaining <= burst_len` and clears the prescaler.
    - If `burst_len=0`, nothing happens: `busy` stays 0 and no strobe is issued.
    - Otherwise `busy` <= 1 and strobes are issued at the RUN rate. `remaining` decrements per strobe, and `busy` drops in the same cycle the last strobe is high.
    - A `step_evt` while `busy` is ignored. Re-triggering becomes possible from the cycle after `busy` falls.
- `tick_count` increments on every cycle `cpu_en` is high and wraps from all-ones to 0.
- `master_reset` mid-burst or mid-debounce returns everything to reset values on the next edge.

## Timing
- `cpu_en` and `busy` come directly from flops; `tick_count` reflects a strobe in the cycle after it.
- RUN: the first strobe is high in cycle `div_val+1` after the mode change edge (cycle 0 = the cycle `mode_q` updates). Period is exactly `div_val+1`.
- STEP latency: `step_btn` is first sampled high at edge E0 and held high. `cpu_en` is high for exactly one cycle, following edge E0 + 2^DB_W + 2.
- A glitch shorter than 2^DB_W cycles after synchronisation produces no strobe.
- BURST: the first strobe is high `div_val+1` cycles after the `step_evt` cycle. Strobes are spaced `div_val+1` apart; the total count is `burst_len`.

## Structure
- Package `cpu_tick_pkg`: mode encoding constants (HALT/RUN/STEP/BURST) and the FSM state enum.
- Submodule `btn_debounce` (param DB_W): synchroniser, debounce counter, rising-edge pulse. Instantiated once.
- The prescaler, FSM, burst counter and tick counter live in `cpu_tick_gen`.
- The top level instantiates `cpu_tick_gen` with default parameters and routes `cpu_en` to the CPU block.

## Test plan
Bench uses CNT_W=8, DB_W=4.
- Reset, mode=01, div_val=3 -> `cpu_en` high in cycles 4, 8, 12; `tick_count`=3 after cycle 12; all outputs 0 while `master_reset`=1.
- mode=10, `step_btn` held high 40 cycles from E0 -> a single `cpu_en` after edge E0+18; a 10-cycle pulse -> no strobe.
- mode=11, div_val=1, burst_len=5, one press -> 5 strobes 2 cycles apart; `busy` high from the event until the 5th strobe; a second press mid-burst is ignored; burst_len=0 -> no strobe, `busy` stays 0.
- RUN, div_val=200 with count at 100, then div_val changed to 10 -> strobe next cycle, then period 11.
- Mid-burst mode change to 00 -> `busy` and `cpu_en` go 0 next cycle; `master_reset` mid-burst -> all outputs 0.
- `tick_count` preloaded near wrap (RUN, div_val=0, 2^16+2 cycles) -> wraps to 0 and keeps counting.
